// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, colour constants and the delay-line stage type.
// VGA_TEST_PATTERN_EN adds the colour-bar index to each delay stage.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int TICK_DIV_DEF = 4;
  localparam int PIPE_DLY_DEF = 1;

  localparam logic [7:0] BG_COLOUR = 8'h49;
  localparam logic [7:0] BAR_COLOUR [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic video;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } pipe_stage_t;

  localparam pipe_stage_t PIPE_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, default: '0};

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus between the sync generator (master) and the overlay/colour selector side (slave).
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic             PIX_TICK;
  logic [CNT_W-1:0] PIX_X;
  logic [CNT_W-1:0] PIX_Y;
  logic             VIDEO_ON;
  logic             FRAME_START;
  logic [7:0]       COLOUR_IN;
  logic [7:0]       RGB;
  logic             HSYNC;
  logic             VSYNC;

  modport master (
    output PIX_TICK, PIX_X, PIX_Y, VIDEO_ON, FRAME_START, RGB, HSYNC, VSYNC,
    input  COLOUR_IN
  );

  modport slave (
    input  PIX_TICK, PIX_X, PIX_Y, VIDEO_ON, FRAME_START, RGB, HSYNC, VSYNC,
    output COLOUR_IN
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with terminal-count flag and raw active-low sync.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LIMIT      = H_TOTAL,
  parameter int SYNC_START = H_DISP + H_FP,
  parameter int SYNC_END   = H_DISP + H_FP + H_SYNC
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_n_o
);

  // One extra bit so a sync end equal to 2**CNT_W still compares correctly.
  localparam logic [CNT_W:0] LAST_C = (CNT_W + 1)'(LIMIT - 1);
  localparam logic [CNT_W:0] SS_C   = (CNT_W + 1)'(SYNC_START);
  localparam logic [CNT_W:0] SE_C   = (CNT_W + 1)'(SYNC_END);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_ext;

  assign count_ext = {1'b0, count_q};
  assign wrap_o    = (count_ext == LAST_C);
  assign sync_n_o  = !((count_ext >= SS_C) && (count_ext < SE_C));
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing: pixel strobe, H/V counters, sync/blank delay line and registered DAC outputs.
// Define VGA_TEST_PATTERN_EN to replace COLOUR_IN with eight vertical colour bars.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int TICK_DIV = vga_pkg::TICK_DIV_DEF,
  parameter int H_DISP   = vga_pkg::H_DISP,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_DISP   = vga_pkg::V_DISP,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int PIPE_DLY = vga_pkg::PIPE_DLY_DEF
) (
  input  logic           CLK_NEXYS,
  input  logic           RESET,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISP);

  if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin : g_bad_total
    $error("vga_sync_gen: raster totals exceed the 10-bit counters");
  end
  if (!is_pow2(TICK_DIV) || TICK_DIV < 2 || TICK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: TICK_DIV must be a power of two in 2..16");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 3) begin : g_bad_dly
    $error("vga_sync_gen: PIPE_DLY must be 1..3");
  end

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, v_wrap, h_sync_n, v_sync_n;
  logic             live_q, frame_start_q;
  logic [7:0]       rgb_q, colour_sel;
  logic             hsync_q, vsync_q;
  pipe_stage_t      raw_stage;
  pipe_stage_t      stage_out [PIPE_DLY+1];

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge CLK_NEXYS) begin
    if (RESET) div_q <= '0;
    else       div_q <= div_q + 1'b1;
  end

  vga_axis_counter #(
    .LIMIT(H_TOT), .SYNC_START(H_DISP + H_FP), .SYNC_END(H_DISP + H_FP + H_SYNC)
  ) u_h_axis (
    .clk(CLK_NEXYS), .srst(RESET), .en_i(tick),
    .count_o(h_count), .wrap_o(h_wrap), .sync_n_o(h_sync_n)
  );

  vga_axis_counter #(
    .LIMIT(V_TOT), .SYNC_START(V_DISP + V_FP), .SYNC_END(V_DISP + V_FP + V_SYNC)
  ) u_v_axis (
    .clk(CLK_NEXYS), .srst(RESET), .en_i(tick & h_wrap),
    .count_o(v_count), .wrap_o(v_wrap), .sync_n_o(v_sync_n)
  );

  always_comb begin
    raw_stage       = PIPE_IDLE;
    raw_stage.hs_n  = h_sync_n;
    raw_stage.vs_n  = v_sync_n;
    raw_stage.video = (h_count < H_DISP_C) && (v_count < V_DISP_C);
`ifdef VGA_TEST_PATTERN_EN
    raw_stage.bar   = h_count[9:7];
`endif
  end

  // Delay line matches the selector's colour latency so blanking/sync line up with COLOUR_IN.
  assign stage_out[0] = raw_stage;

  for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_pipe
    pipe_stage_t stage_q;

    always_ff @(posedge CLK_NEXYS) begin
      if (RESET)     stage_q <= PIPE_IDLE;
      else if (tick) stage_q <= stage_out[gi];
    end

    assign stage_out[gi+1] = stage_q;
  end

  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    colour_sel = BAR_COLOUR[stage_out[PIPE_DLY].bar];
`else
    colour_sel = vga.COLOUR_IN;
`endif
  end

  always_ff @(posedge CLK_NEXYS) begin
    if (RESET) begin
      rgb_q         <= 8'h00;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      live_q        <= 1'b1;
      frame_start_q <= tick & h_wrap & v_wrap;
      if (tick) begin
        rgb_q   <= stage_out[PIPE_DLY].video ? colour_sel : 8'h00;
        hsync_q <= stage_out[PIPE_DLY].hs_n;
        vsync_q <= stage_out[PIPE_DLY].vs_n;
      end
    end
  end

  // live_q holds VIDEO_ON low while in reset even though the counters sit at (0,0).
  assign vga.PIX_TICK    = tick;
  assign vga.PIX_X       = h_count;
  assign vga.PIX_Y       = v_count;
  assign vga.VIDEO_ON    = live_q && (h_count < H_DISP_C) && (v_count < V_DISP_C);
  assign vga.FRAME_START = frame_start_q;
  assign vga.RGB         = rgb_q;
  assign vga.HSYNC       = hsync_q;
  assign vga.VSYNC       = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a 640x480 instance plus a tiny-raster instance for full-frame checks.
// Define VGA_TEST_PATTERN_EN for both RTL and bench to exercise the colour-bar build.
module tb_vga_sync_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  vga_sync_gen_if vif0();
  vga_sync_gen_if vif1();

  vga_sync_gen #(.TICK_DIV(4), .PIPE_DLY(1)) dut0 (.CLK_NEXYS(clk), .RESET(rst0), .vga(vif0));

  vga_sync_gen #(
    .TICK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2)
  ) dut1 (.CLK_NEXYS(clk), .RESET(rst1), .vga(vif1));

  localparam int P_DIV [2] = '{4, 2};
  localparam int P_HD  [2] = '{640, 8};
  localparam int P_HFP [2] = '{16, 2};
  localparam int P_HS  [2] = '{96, 3};
  localparam int P_HT  [2] = '{800, 16};
  localparam int P_VD  [2] = '{480, 4};
  localparam int P_VFP [2] = '{10, 1};
  localparam int P_VS  [2] = '{2, 2};
  localparam int P_VT  [2] = '{525, 8};
  localparam int P_PD  [2] = '{1, 2};

  int checks = 0;
  int failures = 0;

  int m_div [2], m_x [2], m_y [2], m_rgb [2];
  bit m_live [2], m_fs [2], m_hs [2], m_vs [2];
  bit m_phs [2][3], m_pvs [2][3], m_pvid [2][3];
  int m_pbar [2][3];

  int cnt1 = 0, fs1_n = 0, fs1_last = 0, vs1_low = 0, vs1_x = 0, vs1_y = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    if (failures >= 20) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  task automatic model_step(input int i, input bit r, input logic [7:0] col);
    bit tick;
    int last;
    if (r) begin
      m_div[i] = 0; m_x[i] = 0; m_y[i] = 0; m_rgb[i] = 0;
      m_live[i] = 0; m_fs[i] = 0; m_hs[i] = 1; m_vs[i] = 1;
      for (int k = 0; k < 3; k++) begin
        m_phs[i][k] = 1; m_pvs[i][k] = 1; m_pvid[i][k] = 0; m_pbar[i][k] = 0;
      end
    end else begin
      tick = (m_div[i] == P_DIV[i] - 1);
      m_div[i] = (m_div[i] + 1) % P_DIV[i];
      m_fs[i] = tick && (m_x[i] == P_HT[i] - 1) && (m_y[i] == P_VT[i] - 1);
      m_live[i] = 1;
      if (tick) begin
        last = P_PD[i] - 1;
`ifdef VGA_TEST_PATTERN_EN
        m_rgb[i] = m_pvid[i][last] ? int'(BAR_COLOUR[m_pbar[i][last]]) : 0;
`else
        m_rgb[i] = m_pvid[i][last] ? int'(col) : 0;
`endif
        m_hs[i] = m_phs[i][last];
        m_vs[i] = m_pvs[i][last];
        for (int k = 2; k > 0; k--) begin
          m_phs[i][k] = m_phs[i][k-1]; m_pvs[i][k] = m_pvs[i][k-1];
          m_pvid[i][k] = m_pvid[i][k-1]; m_pbar[i][k] = m_pbar[i][k-1];
        end
        m_phs[i][0] = !((m_x[i] >= P_HD[i] + P_HFP[i]) && (m_x[i] < P_HD[i] + P_HFP[i] + P_HS[i]));
        m_pvs[i][0] = !((m_y[i] >= P_VD[i] + P_VFP[i]) && (m_y[i] < P_VD[i] + P_VFP[i] + P_VS[i]));
        m_pvid[i][0] = (m_x[i] < P_HD[i]) && (m_y[i] < P_VD[i]);
        m_pbar[i][0] = (m_x[i] >> 7) & 7;
        if (m_x[i] == P_HT[i] - 1) begin
          m_x[i] = 0;
          m_y[i] = (m_y[i] == P_VT[i] - 1) ? 0 : m_y[i] + 1;
        end else begin
          m_x[i] = m_x[i] + 1;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic tick, input logic [9:0] x, input logic [9:0] y,
                            input logic vid, input logic fs, input logic [7:0] rgb,
                            input logic hs, input logic vs);
    string p;
    p = (i == 0) ? "d0" : "d1";
    chk({p, "_tick"}, int'(tick), int'(m_div[i] == P_DIV[i] - 1));
    chk({p, "_x"}, int'(x), m_x[i]);
    chk({p, "_y"}, int'(y), m_y[i]);
    chk({p, "_video_on"}, int'(vid), int'(m_live[i] && (m_x[i] < P_HD[i]) && (m_y[i] < P_VD[i])));
    chk({p, "_frame_start"}, int'(fs), int'(m_fs[i]));
    chk({p, "_rgb"}, int'(rgb), m_rgb[i]);
    chk({p, "_hsync"}, int'(hs), int'(m_hs[i]));
    chk({p, "_vsync"}, int'(vs), int'(m_vs[i]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0, rst0, vif0.COLOUR_IN);
    model_step(1, rst1, vif1.COLOUR_IN);
    #1;
    check_inst(0, vif0.PIX_TICK, vif0.PIX_X, vif0.PIX_Y, vif0.VIDEO_ON, vif0.FRAME_START,
               vif0.RGB, vif0.HSYNC, vif0.VSYNC);
    check_inst(1, vif1.PIX_TICK, vif1.PIX_X, vif1.PIX_Y, vif1.VIDEO_ON, vif1.FRAME_START,
               vif1.RGB, vif1.HSYNC, vif1.VSYNC);
    if (rst1) cnt1 = 0;
    else      cnt1++;
    // Small raster: 16 x 8 pixels x 2 clocks = 256 cycles per frame, first frame start at cycle 256.
    if (vif1.FRAME_START) begin
      if (fs1_n == 0) chk("d1_fs_first", cnt1, 256);
      else            chk("d1_fs_gap", cnt1 - fs1_last, 256);
      fs1_n++;
      fs1_last = cnt1;
    end
    if (cnt1 >= 256 && cnt1 < 512 && vif1.PIX_TICK && !vif1.VSYNC) begin
      if (vs1_low == 0) begin
        vs1_x = int'(vif1.PIX_X);
        vs1_y = int'(vif1.PIX_Y);
      end
      vs1_low++;
    end
  endtask

  initial begin
    int tc [3], tx [3], n;
    int ticks, hs_low, hs_first, nz, prev_x, inc_prev_x, inc_x;
    int rgb_at [6];
    bit reached;

    rst0 = 1'b1; rst1 = 1'b1;
    vif0.COLOUR_IN = 8'h14; vif1.COLOUR_IN = 8'h14;

    repeat (5) cyc();
    chk("rst_x", int'(vif0.PIX_X), 0);
    chk("rst_y", int'(vif0.PIX_Y), 0);
    chk("rst_tick", int'(vif0.PIX_TICK), 0);
    chk("rst_video_on", int'(vif0.VIDEO_ON), 0);
    chk("rst_frame_start", int'(vif0.FRAME_START), 0);
    chk("rst_rgb", int'(vif0.RGB), 0);
    chk("rst_hsync", int'(vif0.HSYNC), 1);
    chk("rst_vsync", int'(vif0.VSYNC), 1);
    $display("step 1: reset held 5 cycles, outputs at reset values");

    rst0 = 1'b0; rst1 = 1'b0;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (vif0.PIX_TICK && n < 3) begin
        tc[n] = c; tx[n] = int'(vif0.PIX_X); n++;
      end
    end
    chk("tick_count", n, 3);
    chk("tick0_cycle", tc[0], 3);
    chk("tick1_cycle", tc[1], 7);
    chk("tick2_cycle", tc[2], 11);
    chk("tick0_x", tx[0], 0);
    chk("tick1_x", tx[1], 1);
    chk("tick2_x", tx[2], 2);
    $display("step 2: released, ticks every 4 cycles, x reads 0,1,2");

    reached = 0;
    for (int k = 0; k < 4000; k++) begin
      cyc();
      if (vif0.PIX_Y == 10'd1 && vif0.PIX_X == 10'd0) begin reached = 1; break; end
    end
    chk("reach_line1", int'(reached), 1);

    ticks = 0; hs_low = 0; hs_first = -1; nz = 0; prev_x = 0; inc_prev_x = -1; inc_x = -1;
    for (int k = 0; k < 6; k++) rgb_at[k] = -1;
    reached = 0;
    for (int k = 0; k < 4000; k++) begin
      prev_x = int'(vif0.PIX_X);
      cyc();
      if (vif0.PIX_Y == 10'd2) begin
        inc_prev_x = prev_x; inc_x = int'(vif0.PIX_X); reached = 1; break;
      end
      if (vif0.PIX_TICK) begin
        ticks++;
        if (!vif0.HSYNC) begin
          if (hs_first < 0) hs_first = int'(vif0.PIX_X);
          hs_low++;
        end
        if (vif0.RGB != 8'h00) nz++;
        case (int'(vif0.PIX_X))
          1:   rgb_at[0] = int'(vif0.RGB);
          2:   rgb_at[1] = int'(vif0.RGB);
          129: rgb_at[2] = int'(vif0.RGB);
          130: rgb_at[3] = int'(vif0.RGB);
          641: rgb_at[4] = int'(vif0.RGB);
          642: rgb_at[5] = int'(vif0.RGB);
          default: ;
        endcase
      end
    end
    chk("reach_line2", int'(reached), 1);
    chk("line_ticks", ticks, 800);
    chk("hsync_low_ticks", hs_low, 96);
    // Pixel 656 reaches HSYNC two ticks later (one delay stage plus the output register).
    chk("hsync_first_x", hs_first, 658);
    chk("rgb_nonzero_ticks", nz, 640);
    chk("y_inc_prev_x", inc_prev_x, 799);
    chk("y_inc_x", inc_x, 0);
    chk("rgb_x1", rgb_at[0], 0);
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb_x2", rgb_at[1], 8'hFF);
    chk("rgb_x129", rgb_at[2], 8'hFF);
    chk("rgb_x130", rgb_at[3], 8'hFC);
    chk("rgb_x641", rgb_at[4], 8'hE3);
`else
    chk("rgb_x2", rgb_at[1], 8'h14);
    chk("rgb_x129", rgb_at[2], 8'h14);
    chk("rgb_x130", rgb_at[3], 8'h14);
    chk("rgb_x641", rgb_at[4], 8'h14);
`endif
    chk("rgb_x642", rgb_at[5], 0);
    $display("step 3: line 1 timing, hsync width, blanking and colour latency");

    chk("d1_vs_low_ticks", vs1_low, 32);
    chk("d1_vs_first_x", vs1_x, 3);
    chk("d1_vs_first_y", vs1_y, 5);
    chk("d1_fs_count", fs1_n, cnt1 / 256);
    $display("step 4: small raster frame period, vsync lines, frame_start");

    vif0.COLOUR_IN = 8'hA5; vif1.COLOUR_IN = 8'h5A;
    reached = 0;
    for (int k = 0; k < 2000; k++) begin
      cyc();
      if (vif0.PIX_Y == 10'd2 && vif0.PIX_X == 10'd300) begin reached = 1; break; end
    end
    chk("reach_x300", int'(reached), 1);
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb_before_reset", int'(vif0.RGB), 8'h1F);
`else
    chk("rgb_before_reset", int'(vif0.RGB), 8'hA5);
`endif
    rst0 = 1'b1;
    cyc();
    chk("mid_rst_x", int'(vif0.PIX_X), 0);
    chk("mid_rst_y", int'(vif0.PIX_Y), 0);
    chk("mid_rst_hsync", int'(vif0.HSYNC), 1);
    chk("mid_rst_vsync", int'(vif0.VSYNC), 1);
    chk("mid_rst_rgb", int'(vif0.RGB), 0);
    rst0 = 1'b0;
    $display("step 5: reset at x=300 y=2 returns d0 to origin");

    reached = 0;
    for (int k = 0; k < 600; k++) begin
      cyc();
      if (!vif1.VSYNC && vif1.PIX_Y == 10'd6) begin reached = 1; break; end
    end
    chk("d1_reach_vsync", int'(reached), 1);
    rst1 = 1'b1;
    cyc();
    chk("d1_rst_x", int'(vif1.PIX_X), 0);
    chk("d1_rst_y", int'(vif1.PIX_Y), 0);
    chk("d1_rst_vsync", int'(vif1.VSYNC), 1);
    chk("d1_rst_rgb", int'(vif1.RGB), 0);
    rst1 = 1'b0;
    fs1_n = 0; vs1_low = 0;
    repeat (600) cyc();
    chk("d1_fs_after_reset", fs1_n, 2);
    chk("d1_vs_after_reset", vs1_low, 32);
    $display("step 6: reset during vsync, frame restarts from origin");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
